// File: rtl/qoi_decoder_if.sv
// qoi_decoder_if: 6502-style register bus between the CPU and the QOI decoder.
//   cs     : chip select
//   we     : 1 = write, 0 = read
//   addr   : register select (3 bits)
//   data_i : write data from the CPU
//   data_o : read data to the CPU (combinational in the decoder)
interface qoi_decoder_if;
  logic       cs;
  logic       we;
  logic [2:0] addr;
  logic [7:0] data_i;
  logic [7:0] data_o;

  modport master (output cs, we, addr, data_i, input data_o);
  modport slave  (input cs, we, addr, data_i, output data_o);
endinterface

// File: rtl/qoi_decoder.sv
// qoi_decoder: memory-mapped QOI stream decoder. The CPU pushes encoded bytes
// at addr 0 and pops the decoded RGBA pixel one channel per read at addr 0.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : register bus (slave)
//     addr 0 W push byte / R pixel channel
//     addr 3 W {start,clear,...} / R {working,0,0,0,ch_idx[1:0],px_valid,need_byte}
//     addr 4..7 W size[29:0] / R count[29:0], little-endian
module qoi_decoder (
  input  logic            clk,
  input  logic            rst,
  qoi_decoder_if.slave    bus
);

  localparam int unsigned CNT_W = 30;
  localparam int unsigned IDX_N = 64;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] a;
  } pixel_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_OPC  = 3'd1,
    S_ARGS = 3'd2,
    S_EMIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam pixel_t PREV_INIT = '{r: 8'h00, g: 8'h00, b: 8'h00, a: 8'hFF};

  state_t           r_state;
  pixel_t           r_prev;
  pixel_t           r_index [IDX_N];
  logic [7:0]       r_tag;
  logic [7:0]       r_arg   [4];
  logic [1:0]       r_arg_cnt;
  logic [1:0]       r_last_arg;
  logic [5:0]       r_run;
  logic [1:0]       r_ch_idx;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_size;

  logic       w_wr;
  logic       w_rd;
  logic       w_push;
  logic       w_pop;
  logic       w_clear;
  logic       w_start;
  logic       w_working;
  logic       w_need_byte;
  logic       w_px_valid;
  logic       w_commit;
  logic       w_to_args;
  logic [1:0] w_last_arg;
  logic [7:0] w_dg;
  pixel_t     w_px;
  logic [5:0] w_hash;
  logic [CNT_W-1:0] w_count_inc;

  // Colour-index hash, computed directly modulo 64.
  function automatic logic [5:0] px_hash(input pixel_t p);
    return 6'(p.r) * 6'd3 + 6'(p.g) * 6'd5 + 6'(p.b) * 6'd7 + 6'(p.a) * 6'd11;
  endfunction

  assign w_working   = (r_state == S_OPC) || (r_state == S_ARGS) || (r_state == S_EMIT);
  assign w_need_byte = (r_state == S_OPC) || (r_state == S_ARGS);
  assign w_px_valid  = (r_state == S_EMIT);

  // Bus access decode.
  assign w_wr    = bus.cs &  bus.we;
  assign w_rd    = bus.cs & ~bus.we;
  assign w_push  = w_wr && (bus.addr == 3'd0) && w_need_byte;
  assign w_pop   = w_rd && (bus.addr == 3'd0) && w_px_valid;
  assign w_clear = w_wr && (bus.addr == 3'd3) && bus.data_i[6];
  assign w_start = w_wr && (bus.addr == 3'd3) && bus.data_i[7] && !bus.data_i[6];

  assign w_count_inc = r_count + CNT_W'(1);

  // Opcode decode and pixel reconstruction for the byte being pushed.
  always_comb begin
    w_px       = r_prev;
    w_commit   = 1'b0;
    w_to_args  = 1'b0;
    w_last_arg = 2'd0;
    w_dg       = 8'(r_tag[5:0]) - 8'd32;
    if (w_push && r_state == S_OPC) begin
      if (bus.data_i == 8'hFE) begin
        w_to_args  = 1'b1;
        w_last_arg = 2'd2;
      end else if (bus.data_i == 8'hFF) begin
        w_to_args  = 1'b1;
        w_last_arg = 2'd3;
      end else begin
        unique case (bus.data_i[7:6])
          2'b00: begin
            w_px     = r_index[bus.data_i[5:0]];
            w_commit = 1'b1;
          end
          2'b01: begin
            w_px.r   = r_prev.r + 8'(bus.data_i[5:4]) - 8'd2;
            w_px.g   = r_prev.g + 8'(bus.data_i[3:2]) - 8'd2;
            w_px.b   = r_prev.b + 8'(bus.data_i[1:0]) - 8'd2;
            w_commit = 1'b1;
          end
          2'b10: begin
            w_to_args  = 1'b1;
            w_last_arg = 2'd0;
          end
          default: w_commit = 1'b1;  // RUN: pixel is prev
        endcase
      end
    end else if (w_push && r_state == S_ARGS && r_arg_cnt == r_last_arg) begin
      w_commit = 1'b1;
      if (r_tag == 8'hFE) begin
        w_px = '{r: r_arg[0], g: r_arg[1], b: bus.data_i, a: r_prev.a};
      end else if (r_tag == 8'hFF) begin
        w_px = '{r: r_arg[0], g: r_arg[1], b: r_arg[2], a: bus.data_i};
      end else begin
        // LUMA: green delta from the tag, red/blue relative to it.
        w_px.g = r_prev.g + w_dg;
        w_px.r = r_prev.r + w_dg + 8'(bus.data_i[7:4]) - 8'd8;
        w_px.b = r_prev.b + w_dg + 8'(bus.data_i[3:0]) - 8'd8;
      end
    end
  end

  assign w_hash = px_hash(w_px);

  // Decoder state machine and register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_prev     <= PREV_INIT;
      for (int i = 0; i < IDX_N; i++) r_index[i] <= '0;
      for (int i = 0; i < 4; i++) r_arg[i] <= '0;
      r_tag      <= '0;
      r_arg_cnt  <= '0;
      r_last_arg <= '0;
      r_run      <= '0;
      r_ch_idx   <= '0;
      r_count    <= '0;
      r_size     <= '0;
    end else if (w_clear) begin
      r_state  <= S_IDLE;
      r_prev   <= PREV_INIT;
      for (int i = 0; i < IDX_N; i++) r_index[i] <= '0;
      r_run    <= '0;
      r_ch_idx <= '0;
      r_count  <= '0;
    end else begin
      // Pixel commit: becomes prev and lands in the colour index.
      if (w_commit) begin
        r_prev          <= w_px;
        r_index[w_hash] <= w_px;
      end

      unique case (r_state)
        S_IDLE: begin
          if (w_start && r_size != '0) begin
            r_state  <= S_OPC;
            r_count  <= '0;
            r_ch_idx <= '0;
          end
        end
        S_OPC: begin
          if (w_commit) begin
            r_state  <= S_EMIT;
            r_ch_idx <= '0;
            r_run    <= (bus.data_i[7:6] == 2'b11) ? bus.data_i[5:0] : 6'd0;
          end else if (w_to_args) begin
            r_state    <= S_ARGS;
            r_tag      <= bus.data_i;
            r_last_arg <= w_last_arg;
            r_arg_cnt  <= '0;
          end
        end
        S_ARGS: begin
          if (w_commit) begin
            r_state  <= S_EMIT;
            r_ch_idx <= '0;
            r_run    <= '0;
          end else if (w_push) begin
            r_arg[r_arg_cnt] <= bus.data_i;
            r_arg_cnt        <= r_arg_cnt + 2'd1;
          end
        end
        S_EMIT: begin
          if (w_pop) begin
            if (r_ch_idx == 2'd3) begin
              // Pixel consumed; the size limit truncates any pending run.
              r_ch_idx <= '0;
              r_count  <= w_count_inc;
              if (w_count_inc == r_size) begin
                r_state <= S_DONE;
                r_run   <= '0;
              end else if (r_run != '0) begin
                r_run <= r_run - 6'd1;
              end else begin
                r_state <= S_OPC;
              end
            end else begin
              r_ch_idx <= r_ch_idx + 2'd1;
            end
          end
        end
        S_DONE: begin
          if (w_start) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_wr && bus.addr[2] && !w_working) begin
        unique case (bus.addr[1:0])
          2'd0: r_size[7:0]   <= bus.data_i;
          2'd1: r_size[15:8]  <= bus.data_i;
          2'd2: r_size[23:16] <= bus.data_i;
          default: r_size[29:24] <= bus.data_i[5:0];
        endcase
      end
    end
  end

  // Read mux.
  always_comb begin
    bus.data_o = 8'h00;
    unique case (bus.addr)
      3'd0: begin
        if (w_px_valid) begin
          unique case (r_ch_idx)
            2'd0: bus.data_o = r_prev.r;
            2'd1: bus.data_o = r_prev.g;
            2'd2: bus.data_o = r_prev.b;
            default: bus.data_o = r_prev.a;
          endcase
        end
      end
      3'd3: bus.data_o = {w_working, 3'b000, r_ch_idx, w_px_valid, w_need_byte};
      3'd4: bus.data_o = r_count[7:0];
      3'd5: bus.data_o = r_count[15:8];
      3'd6: bus.data_o = r_count[23:16];
      3'd7: bus.data_o = {2'b00, r_count[29:24]};
      default: bus.data_o = 8'h00;
    endcase
  end

endmodule
